// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   muldiv_op_t    : operation encoding presented on the op port
//   muldiv_state_t : control FSM states
//   neg_if()       : conditional two's-complement negation used for sign handling
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;
  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } muldiv_state_t;

  // Negate v when neg is set; used both for magnitudes and for re-applying signs.
  function automatic logic [MULDIV_WIDTH-1:0] neg_if(input logic [MULDIV_WIDTH-1:0] v,
                                                     input logic neg);
    if (neg) begin
      neg_if = -v;
    end else begin
      neg_if = v;
    end
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide datapath.
//   is_div  in   1       selects restoring-divide step (1) or shift-add step (0)
//   acc_in  in   2*WIDTH accumulator before the step
//   opnd    in   WIDTH   multiplicand (multiply) or divisor (divide) magnitude
//   acc_out out  2*WIDTH accumulator after the step
// Multiply: acc = {partial_hi, multiplier_remaining}; add opnd to the upper half when
//           the current multiplier LSB is set, then shift the whole thing right.
// Divide:   acc = {remainder, dividend_remaining/quotient}; shift left, try to
//           subtract the divisor, keep the difference only if it did not go negative.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH-1:0] addend_s;
  logic [WIDTH:0]   add_sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] sub_diff_s;

  // Single shift-add or restore-subtract iteration.
  always_comb begin
    acc_out = acc_in;
    if (acc_in[0]) begin
      addend_s = opnd;
    end else begin
      addend_s = '0;
    end
    // Carry out of the upper half becomes the new MSB after the right shift.
    add_sum_s  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, addend_s};
    rem_sh_s   = acc_in[2*WIDTH-1:WIDTH-1];
    // Only consumed when rem_sh_s >= opnd, so the true difference fits in WIDTH bits.
    sub_diff_s = rem_sh_s[WIDTH-1:0] - opnd;
    if (is_div) begin
      if (rem_sh_s >= {1'b0, opnd}) begin
        acc_out = {sub_diff_s, acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh_s[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_out = {add_sum_s, acc_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative 32-bit MULT/MULTU/DIV/DIVU unit driving the HI/LO write port.
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op, a, b request and operands (sampled only while busy=0)
//   busy            high while an operation is in flight
//   done/hiwr/lowr  one-cycle completion and HI/LO write strobes
//   hi_out, lo_out  product[63:32]/[31:0], or remainder/quotient
// Optional macro MULDIV_FAST_MUL_EN: multiplies bypass CALC and use a single-cycle
// 32x32 multiplier in FIX; divides are unaffected.
// Schedule: the start edge captures raw operands; the next edge loads the
// accumulator from the operand magnitudes (keeps abs/sign logic off the capture
// path); 32 CALC iterations follow, then FIX registers HI/LO and DONE pulses.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             hiwr,
  output logic             lowr,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  muldiv_state_t      state_r, state_nxt_s;
  muldiv_op_t         op_r;
  logic [4:0]         cnt_r;
  logic               init_r;
  logic [WIDTH-1:0]   a_raw_r, b_raw_r;
  logic [2*WIDTH-1:0] acc_r, acc_nxt_s;

  logic               a_neg_s, b_neg_s, res_neg_s, div0_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, step_opnd_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic [WIDTH-1:0]   hi_fix_s, lo_fix_s;

  logic               busy_r, done_r, hiwr_r, lowr_r;
  logic [WIDTH-1:0]   hi_out_r, lo_out_r;

  // Operand signs and magnitudes; unsigned ops never see a negative operand.
  always_comb begin
    a_neg_s     = (op_r == OP_MULT || op_r == OP_DIV) && a_raw_r[WIDTH-1];
    b_neg_s     = (op_r == OP_MULT || op_r == OP_DIV) && b_raw_r[WIDTH-1];
    res_neg_s   = a_neg_s ^ b_neg_s;
    a_mag_s     = neg_if(a_raw_r, a_neg_s);
    b_mag_s     = neg_if(b_raw_r, b_neg_s);
    div0_s      = (b_raw_r == '0);
    if (op_r[1]) begin
      step_opnd_s = b_mag_s;
    end else begin
      step_opnd_s = a_mag_s;
    end
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (op_r[1]),
    .acc_in  (acc_r),
    .opnd    (step_opnd_s),
    .acc_out (acc_nxt_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; the load cycle (init_r) holds the current state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
`ifdef MULDIV_FAST_MUL_EN
          if (!op[1]) begin
            state_nxt_s = ST_FIX;
          end else begin
            state_nxt_s = ST_CALC;
          end
`else
          state_nxt_s = ST_CALC;
`endif
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (!init_r && cnt_r == 5'(MULDIV_ITERS - 1)) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_FIX: begin
        if (init_r) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture, accumulator load and per-iteration update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r    <= OP_MULT;
      a_raw_r <= '0;
      b_raw_r <= '0;
      acc_r   <= '0;
      cnt_r   <= 5'd0;
      init_r  <= 1'b0;
    end else if (state_r == ST_IDLE && start) begin
      op_r    <= muldiv_op_t'(op);
      a_raw_r <= a;
      b_raw_r <= b;
      cnt_r   <= 5'd0;
      init_r  <= 1'b1;
    end else if (init_r) begin
      init_r <= 1'b0;
      if (op_r[1]) begin
        acc_r <= {{WIDTH{1'b0}}, a_mag_s};
      end else begin
        acc_r <= {{WIDTH{1'b0}}, b_mag_s};
      end
    end else if (state_r == ST_CALC) begin
      acc_r <= acc_nxt_s;
      cnt_r <= cnt_r + 5'd1;
    end
  end

  // Sign correction and divide-by-zero override applied in FIX.
  always_comb begin
    prod_s = acc_r;
`ifdef MULDIV_FAST_MUL_EN
    if (!op_r[1]) begin
      prod_s = {{WIDTH{1'b0}}, a_mag_s} * {{WIDTH{1'b0}}, b_mag_s};
    end else begin
      prod_s = acc_r;
    end
`endif
    if (res_neg_s) begin
      prod_fix_s = -prod_s;
    end else begin
      prod_fix_s = prod_s;
    end
    if (op_r[1]) begin
      if (div0_s) begin
        hi_fix_s = a_raw_r;
        lo_fix_s = '1;
      end else begin
        // Remainder follows the dividend sign; quotient truncates toward zero.
        hi_fix_s = neg_if(acc_r[2*WIDTH-1:WIDTH], a_neg_s);
        lo_fix_s = neg_if(acc_r[WIDTH-1:0], res_neg_s);
      end
    end else begin
      hi_fix_s = prod_fix_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_fix_s[WIDTH-1:0];
    end
  end

  // Registered outputs: HI/LO load in FIX, strobes/busy follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      hiwr_r   <= 1'b0;
      lowr_r   <= 1'b0;
      hi_out_r <= '0;
      lo_out_r <= '0;
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= (state_nxt_s == ST_DONE);
      hiwr_r <= (state_nxt_s == ST_DONE);
      lowr_r <= (state_nxt_s == ST_DONE);
      if (state_r == ST_FIX && !init_r) begin
        hi_out_r <= hi_fix_s;
        lo_out_r <= lo_fix_s;
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign hiwr   = hiwr_r;
  assign lowr   = lowr_r;
  assign hi_out = hi_out_r;
  assign lo_out = lo_out_r;

endmodule
